fp_rob_commit: RTL and testbench

//  Dual-issue in-order retirement buffer (ROB) for FP results in the superscalar OoO core.

---
 rtl/fp_core_pkg.sv | 25 ++
 rtl/fp_rob_entry_array.sv | 116 +++++++++++
 rtl/fp_rob_commit.sv | 148 ++++++++++++++
 tb/tb_fp_rob_commit.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_core_pkg.sv
// Shared FP-core definitions: register-file geometry, ROB sizing, the ROB entry
// layout, and the dispatch-slot counting helper used by the retirement buffer.
package fp_core_pkg;

  localparam int FP_REG_W  = 5;
  localparam int FP_DATA_W = 32;
  localparam int ROB_DEPTH = 16;
  localparam int ROB_TAG_W = 4;

  // One retirement-buffer slot as seen by the FP pipeline.
  typedef struct packed {
    logic                 valid;
    logic                 ready;
    logic [FP_REG_W-1:0]  dest;
    logic [FP_DATA_W-1:0] data;
  } rob_entry_t;

  // Number of entries dispatch is asking for. Slot 2 alone is malformed and
  // is treated as no request at all.
  function automatic logic [1:0] alloc_count(input logic req1, input logic req2);
    if (!req1) return 2'd0;
    return req2 ? 2'd2 : 2'd1;
  endfunction

endpackage

// File: rtl/fp_rob_entry_array.sv
// Storage for the FP retirement buffer: DEPTH entries of {valid, ready, dest, data}.
// Two allocate ports, two CDB writeback ports, two clear ports (commit) and two
// combinational read ports. Pointer bookkeeping lives in the parent.
module fp_rob_entry_array
  import fp_core_pkg::*;
#(
  parameter int DEPTH  = ROB_DEPTH,
  parameter int TAG_W  = ROB_TAG_W,
  parameter int DATA_W = FP_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                alloc_en1,
  input  logic                alloc_en2,
  input  logic [TAG_W-1:0]    alloc_idx1,
  input  logic [TAG_W-1:0]    alloc_idx2,
  input  logic [FP_REG_W-1:0] alloc_dest1,
  input  logic [FP_REG_W-1:0] alloc_dest2,
  input  logic                cdb_valid1,
  input  logic                cdb_valid2,
  input  logic [TAG_W-1:0]    cdb_tag1,
  input  logic [TAG_W-1:0]    cdb_tag2,
  input  logic [DATA_W-1:0]   cdb_data1,
  input  logic [DATA_W-1:0]   cdb_data2,
  input  logic                clr_en1,
  input  logic                clr_en2,
  input  logic [TAG_W-1:0]    clr_idx1,
  input  logic [TAG_W-1:0]    clr_idx2,
  input  logic [TAG_W-1:0]    rd_idx1,
  input  logic [TAG_W-1:0]    rd_idx2,
  output logic                rd_valid1,
  output logic                rd_ready1,
  output logic [FP_REG_W-1:0] rd_dest1,
  output logic [DATA_W-1:0]   rd_data1,
  output logic                rd_valid2,
  output logic                rd_ready2,
  output logic [FP_REG_W-1:0] rd_dest2,
  output logic [DATA_W-1:0]   rd_data2
);

  logic [DEPTH-1:0]    valid_q, valid_d;
  logic [DEPTH-1:0]    ready_q, ready_d;
  logic [FP_REG_W-1:0] dest_q [DEPTH];
  logic [FP_REG_W-1:0] dest_d [DEPTH];
  logic [DATA_W-1:0]   data_q [DEPTH];
  logic [DATA_W-1:0]   data_d [DEPTH];

  // Next-state of every entry. Writeback only lands on live entries (port 2
  // last so it wins a tag collision); commit clears; allocation only ever
  // targets free slots so it never collides with the other two.
  always_comb begin
    valid_d = valid_q;
    ready_d = ready_q;
    dest_d  = dest_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = '0;
      ready_d = '0;
    end else begin
      if (cdb_valid1 && valid_q[cdb_tag1]) begin
        ready_d[cdb_tag1] = 1'b1;
        data_d[cdb_tag1]  = cdb_data1;
      end
      if (cdb_valid2 && valid_q[cdb_tag2]) begin
        ready_d[cdb_tag2] = 1'b1;
        data_d[cdb_tag2]  = cdb_data2;
      end
      if (clr_en1) begin
        valid_d[clr_idx1] = 1'b0;
        ready_d[clr_idx1] = 1'b0;
      end
      if (clr_en2) begin
        valid_d[clr_idx2] = 1'b0;
        ready_d[clr_idx2] = 1'b0;
      end
      if (alloc_en1) begin
        valid_d[alloc_idx1] = 1'b1;
        ready_d[alloc_idx1] = 1'b0;
        dest_d[alloc_idx1]  = alloc_dest1;
      end
      if (alloc_en2) begin
        valid_d[alloc_idx2] = 1'b1;
        ready_d[alloc_idx2] = 1'b0;
        dest_d[alloc_idx2]  = alloc_dest2;
      end
    end
  end

  // Entry state registers with asynchronous reset to all-empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      ready_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dest_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      ready_q <= ready_d;
      dest_q  <= dest_d;
      data_q  <= data_d;
    end
  end

  assign rd_valid1 = valid_q[rd_idx1];
  assign rd_ready1 = ready_q[rd_idx1];
  assign rd_dest1  = dest_q[rd_idx1];
  assign rd_data1  = data_q[rd_idx1];
  assign rd_valid2 = valid_q[rd_idx2];
  assign rd_ready2 = ready_q[rd_idx2];
  assign rd_dest2  = dest_q[rd_idx2];
  assign rd_data2  = data_q[rd_idx2];

endmodule

// File: rtl/fp_rob_commit.sv
// Dual-issue in-order FP retirement buffer. Allocates up to two entries per
// cycle at dispatch, captures up to two CDB results per cycle, and retires up
// to two ready entries per cycle in program order into the FP register file.
//
// Handshake: allocation happens on a rising edge where alloc_req1 && alloc_ready
// (alloc_req2 adds the second slot); alloc_ready depends only on registered
// count, flush and the request itself, never on the granted tags. There is no
// back-pressure on the CDB or the register-file write ports: weK is a
// single-cycle strobe and the entry is retired on that same edge.
module fp_rob_commit
  import fp_core_pkg::*;
#(
  parameter int DEPTH  = ROB_DEPTH,
  parameter int TAG_W  = ROB_TAG_W,
  parameter int DATA_W = FP_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                alloc_req1,
  input  logic                alloc_req2,
  input  logic [FP_REG_W-1:0] alloc_dest1,
  input  logic [FP_REG_W-1:0] alloc_dest2,
  output logic                alloc_ready,
  output logic [TAG_W-1:0]    alloc_tag1,
  output logic [TAG_W-1:0]    alloc_tag2,
  input  logic                cdb_valid1,
  input  logic                cdb_valid2,
  input  logic [TAG_W-1:0]    cdb_tag1,
  input  logic [TAG_W-1:0]    cdb_tag2,
  input  logic [DATA_W-1:0]   cdb_data1,
  input  logic [DATA_W-1:0]   cdb_data2,
  output logic                we1,
  output logic                we2,
  output logic [FP_REG_W-1:0] w_addr1,
  output logic [FP_REG_W-1:0] w_addr2,
  output logic [DATA_W-1:0]   w_data1,
  output logic [DATA_W-1:0]   w_data2,
  output logic                full,
  output logic                empty,
  output logic [TAG_W:0]      count
);

  localparam logic [TAG_W:0] DEPTH_CNT = (TAG_W+1)'(DEPTH);

  logic [TAG_W-1:0] head_q, head_d;
  logic [TAG_W-1:0] tail_q, tail_d;
  logic [TAG_W:0]   count_q, count_d;

  logic [1:0]       alloc_n;
  logic             do_alloc;
  logic [1:0]       commit_n;
  logic [TAG_W-1:0] head_p1;

  logic                rd_valid1, rd_ready1, rd_valid2, rd_ready2;
  logic [FP_REG_W-1:0] rd_dest1, rd_dest2;
  logic [DATA_W-1:0]   rd_data1, rd_data2;

  assign head_p1    = head_q + TAG_W'(1);
  assign alloc_tag1 = tail_q;
  assign alloc_tag2 = tail_q + TAG_W'(1);

  // Allocation grant: all-or-nothing against the current free count; a
  // same-cycle commit does not free space early. Flush blocks dispatch.
  always_comb begin
    alloc_n     = alloc_count(alloc_req1, alloc_req2);
    alloc_ready = !flush && ((DEPTH_CNT - count_q) >= (TAG_W+1)'(alloc_n));
    do_alloc    = alloc_ready && (alloc_n != 2'd0);
  end

  // Commit selection from registered entry state; head+1 only retires
  // alongside head, and nothing retires during a flush.
  always_comb begin
    we1      = !flush && rd_valid1 && rd_ready1;
    we2      = we1 && rd_valid2 && rd_ready2;
    w_addr1  = we1 ? rd_dest1 : '0;
    w_data1  = we1 ? rd_data1 : '0;
    w_addr2  = we2 ? rd_dest2 : '0;
    w_data2  = we2 ? rd_data2 : '0;
    commit_n = {1'b0, we1} + {1'b0, we2};
  end

  // Pointer and occupancy next-state.
  always_comb begin
    head_d  = head_q + TAG_W'(commit_n);
    tail_d  = do_alloc ? tail_q + TAG_W'(alloc_n) : tail_q;
    count_d = count_q + (do_alloc ? (TAG_W+1)'(alloc_n) : '0) - (TAG_W+1)'(commit_n);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign full  = (count_q == DEPTH_CNT);
  assign empty = (count_q == '0);

  fp_rob_entry_array #(
    .DEPTH  (DEPTH),
    .TAG_W  (TAG_W),
    .DATA_W (DATA_W)
  ) u_entries (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .alloc_en1   (do_alloc),
    .alloc_en2   (do_alloc && (alloc_n == 2'd2)),
    .alloc_idx1  (alloc_tag1),
    .alloc_idx2  (alloc_tag2),
    .alloc_dest1 (alloc_dest1),
    .alloc_dest2 (alloc_dest2),
    .cdb_valid1  (cdb_valid1),
    .cdb_valid2  (cdb_valid2),
    .cdb_tag1    (cdb_tag1),
    .cdb_tag2    (cdb_tag2),
    .cdb_data1   (cdb_data1),
    .cdb_data2   (cdb_data2),
    .clr_en1     (we1),
    .clr_en2     (we2),
    .clr_idx1    (head_q),
    .clr_idx2    (head_p1),
    .rd_idx1     (head_q),
    .rd_idx2     (head_p1),
    .rd_valid1   (rd_valid1),
    .rd_ready1   (rd_ready1),
    .rd_dest1    (rd_dest1),
    .rd_data1    (rd_data1),
    .rd_valid2   (rd_valid2),
    .rd_ready2   (rd_ready2),
    .rd_dest2    (rd_dest2),
    .rd_data2    (rd_data2)
  );

endmodule

// File: tb/tb_fp_rob_commit.sv
// Bench for fp_rob_commit: a table of per-cycle vectors for the basic
// alloc/writeback/commit flow, then hand-written sequences for fill, wrap,
// flush and asynchronous reset.
module tb_fp_rob_commit;
  import fp_core_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        flush;
  logic        alloc_req1, alloc_req2;
  logic [4:0]  alloc_dest1, alloc_dest2;
  logic        alloc_ready;
  logic [3:0]  alloc_tag1, alloc_tag2;
  logic        cdb_valid1, cdb_valid2;
  logic [3:0]  cdb_tag1, cdb_tag2;
  logic [31:0] cdb_data1, cdb_data2;
  logic        we1, we2;
  logic [4:0]  w_addr1, w_addr2;
  logic [31:0] w_data1, w_data2;
  logic        full, empty;
  logic [4:0]  count;

  fp_rob_commit dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_req1(alloc_req1), .alloc_req2(alloc_req2),
    .alloc_dest1(alloc_dest1), .alloc_dest2(alloc_dest2),
    .alloc_ready(alloc_ready), .alloc_tag1(alloc_tag1), .alloc_tag2(alloc_tag2),
    .cdb_valid1(cdb_valid1), .cdb_valid2(cdb_valid2),
    .cdb_tag1(cdb_tag1), .cdb_tag2(cdb_tag2),
    .cdb_data1(cdb_data1), .cdb_data2(cdb_data2),
    .we1(we1), .we2(we2), .w_addr1(w_addr1), .w_addr2(w_addr2),
    .w_data1(w_data1), .w_data2(w_data2),
    .full(full), .empty(empty), .count(count)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [36:0] exp_q[$];   // {dest, data} in program order

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    flush = 1'b0;
    alloc_req1 = 1'b0; alloc_req2 = 1'b0; alloc_dest1 = '0; alloc_dest2 = '0;
    cdb_valid1 = 1'b0; cdb_valid2 = 1'b0; cdb_tag1 = '0; cdb_tag2 = '0;
    cdb_data1 = '0; cdb_data2 = '0;
  endtask

  // Advance one clock; inputs change only at posedge+1.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        r1, r2;
    logic [4:0]  d1, d2;
    logic        cv1;
    logic [3:0]  ct1;
    logic [31:0] cd1;
    logic        cv2;
    logic [3:0]  ct2;
    logic [31:0] cd2;
    logic        e_ar;
    logic [3:0]  e_t1, e_t2;
    logic        e_we1, e_we2;
    logic [4:0]  e_a1, e_a2;
    logic [31:0] e_d1, e_d2;
    logic [4:0]  e_cnt;
    logic        e_full, e_empty;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  task automatic fill_vectors();
    //          r1 r2 d1 d2  cv1 ct1 cd1           cv2 ct2 cd2           ar t1 t2 we1 we2 a1 a2 d1            d2            cnt fu em
    vecs[0]  = '{0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 0, 1, 0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 1};
    vecs[1]  = '{1, 1, 3, 5, 0, 0, 32'h0,        0, 0, 32'h0,        1, 0, 1, 0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 1};
    vecs[2]  = '{0, 0, 0, 0, 1, 1, 32'h40490FDB, 0, 0, 32'h0,        1, 2, 3, 0, 0, 0, 0, 32'h0,        32'h0,        2, 0, 0};
    vecs[3]  = '{0, 0, 0, 0, 1, 0, 32'h3F800000, 0, 0, 32'h0,        1, 2, 3, 0, 0, 0, 0, 32'h0,        32'h0,        2, 0, 0};
    vecs[4]  = '{0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 2, 3, 1, 1, 3, 5, 32'h3F800000, 32'h40490FDB, 2, 0, 0};
    vecs[5]  = '{1, 1, 7, 7, 0, 0, 32'h0,        0, 0, 32'h0,        1, 2, 3, 0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 1};
    vecs[6]  = '{0, 0, 0, 0, 1, 2, 32'h11111111, 1, 3, 32'h22222222, 1, 4, 5, 0, 0, 0, 0, 32'h0,        32'h0,        2, 0, 0};
    vecs[7]  = '{0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 4, 5, 1, 1, 7, 7, 32'h11111111, 32'h22222222, 2, 0, 0};
    vecs[8]  = '{0, 1, 0, 9, 0, 0, 32'h0,        0, 0, 32'h0,        1, 4, 5, 0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 1};
    vecs[9]  = '{1, 0, 9, 0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 4, 5, 0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 1};
    vecs[10] = '{0, 0, 0, 0, 1, 4, 32'h0000AAAA, 1, 4, 32'h0000BBBB, 1, 5, 6, 0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 0};
    vecs[11] = '{0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 5, 6, 1, 0, 9, 0, 32'h0000BBBB, 32'h0,        1, 0, 0};
    vecs[12] = '{0, 0, 0, 0, 1, 5, 32'h55555555, 0, 0, 32'h0,        1, 5, 6, 0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 1};
    vecs[13] = '{1, 0, 2, 0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 5, 6, 0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 1};
    vecs[14] = '{0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 6, 7, 0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 0};
    vecs[15] = '{0, 0, 0, 0, 1, 5, 32'h12345678, 0, 0, 32'h0,        1, 6, 7, 0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 0};
    vecs[16] = '{0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 6, 7, 1, 0, 2, 0, 32'h12345678, 32'h0,        1, 0, 0};
    vecs[17] = '{0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 6, 7, 0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 1};
  endtask

  task automatic run_vectors();
    for (int i = 0; i < NV; i++) begin
      alloc_req1 = vecs[i].r1;  alloc_req2 = vecs[i].r2;
      alloc_dest1 = vecs[i].d1; alloc_dest2 = vecs[i].d2;
      cdb_valid1 = vecs[i].cv1; cdb_tag1 = vecs[i].ct1; cdb_data1 = vecs[i].cd1;
      cdb_valid2 = vecs[i].cv2; cdb_tag2 = vecs[i].ct2; cdb_data2 = vecs[i].cd2;
      #1;
      chk($sformatf("v%0d.alloc_ready", i), 64'(alloc_ready), 64'(vecs[i].e_ar));
      chk($sformatf("v%0d.alloc_tag1", i), 64'(alloc_tag1), 64'(vecs[i].e_t1));
      chk($sformatf("v%0d.alloc_tag2", i), 64'(alloc_tag2), 64'(vecs[i].e_t2));
      chk($sformatf("v%0d.we1", i), 64'(we1), 64'(vecs[i].e_we1));
      chk($sformatf("v%0d.we2", i), 64'(we2), 64'(vecs[i].e_we2));
      chk($sformatf("v%0d.w_addr1", i), 64'(w_addr1), 64'(vecs[i].e_a1));
      chk($sformatf("v%0d.w_addr2", i), 64'(w_addr2), 64'(vecs[i].e_a2));
      chk($sformatf("v%0d.w_data1", i), 64'(w_data1), 64'(vecs[i].e_d1));
      chk($sformatf("v%0d.w_data2", i), 64'(w_data2), 64'(vecs[i].e_d2));
      chk($sformatf("v%0d.count", i), 64'(count), 64'(vecs[i].e_cnt));
      chk($sformatf("v%0d.full", i), 64'(full), 64'(vecs[i].e_full));
      chk($sformatf("v%0d.empty", i), 64'(empty), 64'(vecs[i].e_empty));
      step();
    end
    idle_inputs();
  endtask

  // ---------------- hand-written sequences ----------------
  task automatic test_fill();
    logic [3:0] t;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      alloc_req1 = 1'b1; alloc_req2 = 1'b1;
      alloc_dest1 = 5'(2 * i); alloc_dest2 = 5'(2 * i + 1);
      step();
    end
    alloc_req2 = 1'b0; alloc_dest1 = 5'd14;
    step();
    idle_inputs();
    #1;
    chk("fill.count15", 64'(count), 64'd15);
    chk("fill.not_full15", 64'(full), 64'd0);
    alloc_req1 = 1'b1; alloc_req2 = 1'b1; alloc_dest1 = 5'd20; alloc_dest2 = 5'd21;
    #1;
    chk("fill.ready_req2", 64'(alloc_ready), 64'd0);
    t = 4'd0;
    chk("fill.tag2_wrap", 64'(alloc_tag2), 64'(t));
    step();
    alloc_req1 = 1'b0; alloc_req2 = 1'b0;
    #1;
    chk("fill.count_after_reject", 64'(count), 64'd15);
    alloc_req1 = 1'b1; alloc_dest1 = 5'd22;
    #1;
    chk("fill.ready_req1", 64'(alloc_ready), 64'd1);
    chk("fill.tag15", 64'(alloc_tag1), 64'd15);
    step();
    #1;
    chk("fill.full", 64'(full), 64'd1);
    chk("fill.count16", 64'(count), 64'd16);
    chk("fill.ready_when_full", 64'(alloc_ready), 64'd0);
    idle_inputs();
  endtask

  task automatic test_wrap();
    logic [36:0] e;
    logic [3:0]  ta, tb;
    logic [31:0] da, db;
    do_reset();
    exp_q.delete();
    for (int it = 0; it < 10; it++) begin
      ta = 4'((2 * it) % 16);
      tb = 4'((2 * it + 1) % 16);
      da = 32'hC000_0000 + 32'(2 * it);
      db = 32'hC000_0000 + 32'(2 * it + 1);
      alloc_req1 = 1'b1; alloc_req2 = 1'b1;
      alloc_dest1 = 5'(2 * it + 1); alloc_dest2 = 5'(2 * it + 2);
      #1;
      chk($sformatf("wrap%0d.tag1", it), 64'(alloc_tag1), 64'(ta));
      chk($sformatf("wrap%0d.tag2", it), 64'(alloc_tag2), 64'(tb));
      exp_q.push_back({alloc_dest1, da});
      exp_q.push_back({alloc_dest2, db});
      step();
      idle_inputs();
      // Odd iterations deliver the younger result on port 1.
      cdb_valid1 = 1'b1; cdb_valid2 = 1'b1;
      if (it % 2 == 1) begin
        cdb_tag1 = tb; cdb_data1 = db; cdb_tag2 = ta; cdb_data2 = da;
      end else begin
        cdb_tag1 = ta; cdb_data1 = da; cdb_tag2 = tb; cdb_data2 = db;
      end
      #1;
      chk($sformatf("wrap%0d.no_early_we1", it), 64'(we1), 64'd0);
      step();
      idle_inputs();
      #1;
      chk($sformatf("wrap%0d.we1", it), 64'(we1), 64'd1);
      chk($sformatf("wrap%0d.we2", it), 64'(we2), 64'd1);
      e = exp_q.pop_front();
      chk($sformatf("wrap%0d.port1", it), 64'({w_addr1, w_data1}), 64'(e));
      e = exp_q.pop_front();
      chk($sformatf("wrap%0d.port2", it), 64'({w_addr2, w_data2}), 64'(e));
      step();
    end
    #1;
    chk("wrap.count0", 64'(count), 64'd0);
    chk("wrap.empty", 64'(empty), 64'd1);
    chk("wrap.next_tag", 64'(alloc_tag1), 64'd4);
  endtask

  task automatic test_flush_and_reset();
    do_reset();
    alloc_req1 = 1'b1; alloc_req2 = 1'b1; alloc_dest1 = 5'd1; alloc_dest2 = 5'd2;
    step();
    alloc_req2 = 1'b0; alloc_dest1 = 5'd3;
    step();
    idle_inputs();
    cdb_valid1 = 1'b1; cdb_tag1 = 4'd2; cdb_data1 = 32'h0BAD_F00D;
    step();
    idle_inputs();
    #1;
    chk("flush.pre_we1", 64'(we1), 64'd0);
    chk("flush.pre_count", 64'(count), 64'd3);
    flush = 1'b1;
    alloc_req1 = 1'b1; alloc_dest1 = 5'd4;
    cdb_valid1 = 1'b1; cdb_tag1 = 4'd0; cdb_data1 = 32'h1111_2222;
    #1;
    chk("flush.ready_blocked", 64'(alloc_ready), 64'd0);
    chk("flush.we1_in_flush", 64'(we1), 64'd0);
    step();
    idle_inputs();
    #1;
    chk("flush.empty", 64'(empty), 64'd1);
    chk("flush.count", 64'(count), 64'd0);
    chk("flush.tag_restart", 64'(alloc_tag1), 64'd0);
    chk("flush.post_we1", 64'(we1), 64'd0);
    step();
    #1;
    chk("flush.idle_we1", 64'(we1), 64'd0);

    // Asynchronous reset asserted between edges while a commit is presented.
    do_reset();
    alloc_req1 = 1'b1; alloc_dest1 = 5'd12;
    step();
    idle_inputs();
    cdb_valid1 = 1'b1; cdb_tag1 = 4'd0; cdb_data1 = 32'hDEAD_BEEF;
    step();
    idle_inputs();
    #1;
    chk("arst.pre_we1", 64'(we1), 64'd1);
    chk("arst.pre_addr", 64'(w_addr1), 64'd12);
    #2;
    rst = 1'b1;
    #1;
    chk("arst.we1", 64'(we1), 64'd0);
    chk("arst.w_addr1", 64'(w_addr1), 64'd0);
    chk("arst.w_data1", 64'(w_data1), 64'd0);
    chk("arst.empty", 64'(empty), 64'd1);
    chk("arst.count", 64'(count), 64'd0);
    chk("arst.alloc_ready", 64'(alloc_ready), 64'd1);
    #1;
    rst = 1'b0;
    step();
    #1;
    chk("arst.post_we1", 64'(we1), 64'd0);
    chk("arst.post_empty", 64'(empty), 64'd1);
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    idle_inputs();
    fill_vectors();
    do_reset();
    run_vectors();
    test_fill();
    test_wrap();
    test_flush_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t required below 200000", $time);
    $fatal(1);
  end

endmodule
